sram_rr_arbiter: RTL and testbench



---
 rtl/sram_rr_arbiter_if.sv | 34 +++
 rtl/sram_rr_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_sram_rr_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_rr_arbiter_if.sv
// Requester-side request/response bundle for sram_rr_arbiter.
// One instance per requester.
//   master : requester side. Drives valid/we/addr/wdata; receives ready and the response.
//   slave  : arbiter side. Receives the request; drives ready, rsp_valid, rsp_rdata and rsp_err.
// Signals:
//   valid/ready      request handshake; a request is accepted when both are high at posedge
//   we               1 = write, 0 = read
//   addr, wdata      request address and write data
//   rsp_valid        one-cycle read response strobe
//   rsp_rdata        read data; holds until the next read response
//   rsp_err          one-cycle error strobe (optional address check)
interface sram_rr_arbiter_if #(
  parameter int unsigned ADDR = 8,
  parameter int unsigned DATA = 8
);
  logic            valid;
  logic            ready;
  logic            we;
  logic [ADDR-1:0] addr;
  logic [DATA-1:0] wdata;
  logic            rsp_valid;
  logic [DATA-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/sram_rr_arbiter.sv
// Two-requester round-robin arbiter and sequencer in front of a single-port synchronous SRAM
// with a one-cycle registered read. Accesses are serialised as IDLE -> ACCESS (-> CAPTURE for
// reads) -> IDLE. The SRAM strobes are registered, so they are high for exactly the ACCESS cycle.
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   req_a, req_b   requester bundles (sram_rr_arbiter_if.slave)
//   sram_cs/we/rd  SRAM chip select, write enable, read enable
//   sram_addr/din  SRAM address and write data
//   sram_dout      SRAM read data, valid the cycle after the rd cycle
// Optional feature: define ADDR_CHECK_EN to reject addresses >= DEPTH. A rejected access makes
// no SRAM access and reports rsp_err; a rejected read also returns zero data with rsp_valid.
module sram_rr_arbiter #(
  parameter int unsigned ADDR  = 8,
  parameter int unsigned DATA  = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_rr_arbiter_if.slave     req_a,
  sram_rr_arbiter_if.slave     req_b,
  output logic                 sram_cs,
  output logic                 sram_we,
  output logic                 sram_rd,
  output logic [ADDR-1:0]      sram_addr,
  output logic [DATA-1:0]      sram_din,
  input  logic [DATA-1:0]      sram_dout
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StAccess  = 2'd1;
  localparam logic [1:0] StCapture = 2'd2;

  // The SRAM cannot hold more words than the address can reach.
  if (64'(DEPTH) > (64'd1 << ADDR)) begin : g_depth_chk
    $error("DEPTH exceeds the addressable range of ADDR");
  end

  logic [1:0]      state_q, state_d;
  logic            last_q, last_d;    // owner of the latest grant: 0 = A, 1 = B
  logic            owner_q, owner_d;
  logic            we_q, we_d;
  logic            bad_q, bad_d;      // accepted address failed the range check
  logic            sram_cs_q, sram_cs_d;
  logic            sram_we_q, sram_we_d;
  logic            sram_rd_q, sram_rd_d;
  logic [ADDR-1:0] sram_addr_q, sram_addr_d;
  logic [DATA-1:0] sram_din_q, sram_din_d;
  logic            a_rsp_valid_q, a_rsp_valid_d, b_rsp_valid_q, b_rsp_valid_d;
  logic            a_rsp_err_q, a_rsp_err_d, b_rsp_err_q, b_rsp_err_d;
  logic [DATA-1:0] a_rsp_rdata_q, a_rsp_rdata_d, b_rsp_rdata_q, b_rsp_rdata_d;

  logic            idle;
  logic            gnt_b;
  logic            accept;
  logic            sel_we;
  logic [ADDR-1:0] sel_addr;
  logic [DATA-1:0] sel_wdata;
  logic            sel_bad;

  // Ready is masked during reset so both readies read 0 while rst is held.
  assign idle   = (state_q == StIdle) && !rst;
  // On a tie the requester that did not win last time is granted.
  assign gnt_b  = (req_a.valid && req_b.valid) ? ~last_q : req_b.valid;
  assign accept = idle && (req_a.valid || req_b.valid);

  assign req_a.ready = idle && req_a.valid && !gnt_b;
  assign req_b.ready = idle && req_b.valid && gnt_b;

  assign sel_we    = gnt_b ? req_b.we    : req_a.we;
  assign sel_addr  = gnt_b ? req_b.addr  : req_a.addr;
  assign sel_wdata = gnt_b ? req_b.wdata : req_a.wdata;

`ifdef ADDR_CHECK_EN
  assign sel_bad = (64'(sel_addr) >= 64'(DEPTH));
`else
  assign sel_bad = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    owner_d       = owner_q;
    we_d          = we_q;
    bad_d         = bad_q;
    sram_cs_d     = 1'b0;
    sram_we_d     = 1'b0;
    sram_rd_d     = 1'b0;
    sram_addr_d   = '0;
    sram_din_d    = '0;
    a_rsp_valid_d = 1'b0;
    b_rsp_valid_d = 1'b0;
    a_rsp_err_d   = 1'b0;
    b_rsp_err_d   = 1'b0;
    a_rsp_rdata_d = a_rsp_rdata_q;
    b_rsp_rdata_d = b_rsp_rdata_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          owner_d     = gnt_b;
          last_d      = gnt_b;
          we_d        = sel_we;
          bad_d       = sel_bad;
          // Strobes are loaded here so they are live for exactly the ACCESS cycle.
          sram_cs_d   = !sel_bad;
          sram_we_d   = !sel_bad && sel_we;
          sram_rd_d   = !sel_bad && !sel_we;
          sram_addr_d = sel_addr;
          sram_din_d  = sel_wdata;
          state_d     = StAccess;
        end
      end
      StAccess: begin
        if (we_q) begin
          // Writes never respond, except to flag a rejected address.
          a_rsp_err_d = bad_q && !owner_q;
          b_rsp_err_d = bad_q && owner_q;
          state_d     = StIdle;
        end else begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        if (owner_q) begin
          b_rsp_valid_d = 1'b1;
          b_rsp_err_d   = bad_q;
          b_rsp_rdata_d = bad_q ? '0 : sram_dout;
        end else begin
          a_rsp_valid_d = 1'b1;
          a_rsp_err_d   = bad_q;
          a_rsp_rdata_d = bad_q ? '0 : sram_dout;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      last_q        <= 1'b1;
      owner_q       <= 1'b0;
      we_q          <= 1'b0;
      bad_q         <= 1'b0;
      sram_cs_q     <= 1'b0;
      sram_we_q     <= 1'b0;
      sram_rd_q     <= 1'b0;
      sram_addr_q   <= '0;
      sram_din_q    <= '0;
      a_rsp_valid_q <= 1'b0;
      b_rsp_valid_q <= 1'b0;
      a_rsp_err_q   <= 1'b0;
      b_rsp_err_q   <= 1'b0;
      a_rsp_rdata_q <= '0;
      b_rsp_rdata_q <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      owner_q       <= owner_d;
      we_q          <= we_d;
      bad_q         <= bad_d;
      sram_cs_q     <= sram_cs_d;
      sram_we_q     <= sram_we_d;
      sram_rd_q     <= sram_rd_d;
      sram_addr_q   <= sram_addr_d;
      sram_din_q    <= sram_din_d;
      a_rsp_valid_q <= a_rsp_valid_d;
      b_rsp_valid_q <= b_rsp_valid_d;
      a_rsp_err_q   <= a_rsp_err_d;
      b_rsp_err_q   <= b_rsp_err_d;
      a_rsp_rdata_q <= a_rsp_rdata_d;
      b_rsp_rdata_q <= b_rsp_rdata_d;
    end
  end

  assign sram_cs   = sram_cs_q;
  assign sram_we   = sram_we_q;
  assign sram_rd   = sram_rd_q;
  assign sram_addr = sram_addr_q;
  assign sram_din  = sram_din_q;

  assign req_a.rsp_valid = a_rsp_valid_q;
  assign req_a.rsp_rdata = a_rsp_rdata_q;
  assign req_a.rsp_err   = a_rsp_err_q;
  assign req_b.rsp_valid = b_rsp_valid_q;
  assign req_b.rsp_rdata = b_rsp_rdata_q;
  assign req_b.rsp_err   = b_rsp_err_q;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter with a behavioural single-port SRAM (registered read).
module tb_sram_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       sram_cs, sram_we, sram_rd;
  logic [7:0] sram_addr, sram_din;
  logic [7:0] sram_dout;
  logic [7:0] mem [256];

  int n_checks  = 0;
  int n_fail    = 0;
  int both_cnt  = 0;
  int a_rsp_cnt = 0;
  int b_rsp_cnt = 0;
  int base;
  int gnt_log [$];

  sram_rr_arbiter_if #(.ADDR(8), .DATA(8)) req_a ();
  sram_rr_arbiter_if #(.ADDR(8), .DATA(8)) req_b ();

  sram_rr_arbiter #(.ADDR(8), .DATA(8), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_a     (req_a),
    .req_b     (req_b),
    .sram_cs   (sram_cs),
    .sram_we   (sram_we),
    .sram_rd   (sram_rd),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout)
  );

  always #5 clk = ~clk;

  // SRAM model: write and registered read on the clock edge.
  always @(posedge clk) begin
    if (sram_cs && sram_we) mem[sram_addr] <= sram_din;
    if (sram_cs && sram_rd) sram_dout <= mem[sram_addr];
  end

  // Observers sample mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (sram_we && sram_rd) both_cnt++;
    if (req_a.rsp_valid) a_rsp_cnt++;
    if (req_b.rsp_valid) b_rsp_cnt++;
    if (req_a.valid && req_a.ready) gnt_log.push_back(0);
    if (req_b.valid && req_b.ready) gnt_log.push_back(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[1] = 8'h11; mem[2] = 8'h22; mem[7] = 8'h77; mem[9] = 8'h99;
    sram_dout = 8'h00;
    req_a.valid = 1'b1; req_a.we = 1'b0; req_a.addr = 8'd0; req_a.wdata = 8'd0;
    req_b.valid = 1'b1; req_b.we = 1'b0; req_b.addr = 8'd0; req_b.wdata = 8'd0;
    rst = 1'b1;

    // Reset state: valids high, yet nothing may be granted.
    #3;
    check_eq("rst_a_ready", 32'(req_a.ready), 0);
    check_eq("rst_b_ready", 32'(req_b.ready), 0);
    check_eq("rst_sram_cs", 32'(sram_cs), 0);
    check_eq("rst_a_rsp", 32'(req_a.rsp_valid), 0);
    tick();
    req_a.valid = 1'b0; req_b.valid = 1'b0;
    rst = 1'b0;

    // Write then read, A only.
    req_a.valid = 1'b1; req_a.we = 1'b1; req_a.addr = 8'd3; req_a.wdata = 8'hA5;
    #1 check_eq("t1_a_ready", 32'(req_a.ready), 1);
    tick();
    req_a.valid = 1'b0;
    check_eq("t1_wr_cs", 32'(sram_cs), 1);
    check_eq("t1_wr_we", 32'(sram_we), 1);
    check_eq("t1_wr_rd", 32'(sram_rd), 0);
    check_eq("t1_wr_addr", 32'(sram_addr), 3);
    check_eq("t1_wr_din", 32'(sram_din), 32'hA5);
    tick();
    check_eq("t1_wr_we_off", 32'(sram_we), 0);
    check_eq("t1_mem3", 32'(mem[3]), 32'hA5);
    req_a.valid = 1'b1; req_a.we = 1'b0; req_a.addr = 8'd3;
    #1 check_eq("t1_rd_ready", 32'(req_a.ready), 1);
    tick();
    req_a.valid = 1'b0;
    check_eq("t1_rd_rd", 32'(sram_rd), 1);
    check_eq("t1_rd_we", 32'(sram_we), 0);
    check_eq("t1_ready_busy", 32'(req_a.ready), 0);
    tick();
    check_eq("t1_cap_cs", 32'(sram_cs), 0);
    check_eq("t1_cap_rsp", 32'(req_a.rsp_valid), 0);
    tick();
    check_eq("t1_rsp_valid", 32'(req_a.rsp_valid), 1);
    check_eq("t1_rsp_rdata", 32'(req_a.rsp_rdata), 32'hA5);
    check_eq("t1_rsp_err", 32'(req_a.rsp_err), 0);
    tick();
    check_eq("t1_rsp_pulse", 32'(req_a.rsp_valid), 0);
    check_eq("t1_rdata_hold", 32'(req_a.rsp_rdata), 32'hA5);

    // Simultaneous reads straight from reset.
    rst = 1'b1;
    #1 check_eq("t2_rst_rdata", 32'(req_a.rsp_rdata), 0);
    tick();
    rst = 1'b0;
    req_a.valid = 1'b1; req_a.we = 1'b0; req_a.addr = 8'd1;
    req_b.valid = 1'b1; req_b.we = 1'b0; req_b.addr = 8'd2;
    #1;
    check_eq("t2_a_first", 32'(req_a.ready), 1);
    check_eq("t2_b_wait", 32'(req_b.ready), 0);
    tick();
    req_a.valid = 1'b0;
    check_eq("t2_b_wait_acc", 32'(req_b.ready), 0);
    tick();
    check_eq("t2_b_wait_cap", 32'(req_b.ready), 0);
    tick();
    check_eq("t2_a_rsp", 32'(req_a.rsp_valid), 1);
    check_eq("t2_a_rdata", 32'(req_a.rsp_rdata), 32'h11);
    check_eq("t2_b_ready", 32'(req_b.ready), 1);
    tick();
    req_b.valid = 1'b0;
    check_eq("t2_b_addr", 32'(sram_addr), 2);
    tick();
    tick();
    check_eq("t2_b_rsp", 32'(req_b.rsp_valid), 1);
    check_eq("t2_b_rdata", 32'(req_b.rsp_rdata), 32'h22);
    check_eq("t2_a_hold", 32'(req_a.rsp_rdata), 32'h11);
    tick();

    // Continuous contention: both hold valid writes for eight grants.
    gnt_log.delete();
    base = a_rsp_cnt + b_rsp_cnt;
    req_a.valid = 1'b1; req_a.we = 1'b1; req_a.addr = 8'd4; req_a.wdata = 8'h44;
    req_b.valid = 1'b1; req_b.we = 1'b1; req_b.addr = 8'd5; req_b.wdata = 8'h55;
    for (int c = 0; c < 40 && gnt_log.size() < 8; c++) tick();
    req_a.valid = 1'b0; req_b.valid = 1'b0;
    check_eq("t3_grant_count", 32'(gnt_log.size()), 8);
    for (int i = 0; i < gnt_log.size() && i < 8; i++)
      check_eq($sformatf("t3_grant%0d", i), 32'(gnt_log[i]), 32'(i % 2));
    tick();
    tick();
    check_eq("t3_mem4", 32'(mem[4]), 32'h44);
    check_eq("t3_mem5", 32'(mem[5]), 32'h55);
    check_eq("t3_no_wr_rsp", 32'(a_rsp_cnt + b_rsp_cnt - base), 0);

    // Reset in the ACCESS cycle of a read abandons it.
    req_b.valid = 1'b1; req_b.we = 1'b0; req_b.addr = 8'd1;
    tick();
    req_b.valid = 1'b0;
    check_eq("t4_access_cs", 32'(sram_cs), 1);
    base = b_rsp_cnt;
    rst = 1'b1;
    #1;
    check_eq("t4_cs_drop", 32'(sram_cs), 0);
    check_eq("t4_rd_drop", 32'(sram_rd), 0);
    tick();
    rst = 1'b0;
    req_a.valid = 1'b1; req_a.we = 1'b1; req_a.addr = 8'd6; req_a.wdata = 8'h66;
    req_b.valid = 1'b1; req_b.we = 1'b1; req_b.addr = 8'd6; req_b.wdata = 8'h67;
    #1;
    check_eq("t4_a_tie", 32'(req_a.ready), 1);
    check_eq("t4_b_tie", 32'(req_b.ready), 0);
    tick();
    req_a.valid = 1'b0; req_b.valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("t4_no_rsp", 32'(b_rsp_cnt - base), 0);

    // Back-to-back B reads of addresses 0 and 7.
    base = b_rsp_cnt;
    req_b.valid = 1'b1; req_b.we = 1'b0; req_b.addr = 8'd0;
    tick();
    req_b.addr = 8'd7;
    tick();
    tick();
    check_eq("t5_rsp0", 32'(req_b.rsp_valid), 1);
    check_eq("t5_rdata0", 32'(req_b.rsp_rdata), 32'h00);
    tick();
    req_b.valid = 1'b0;
    tick();
    tick();
    check_eq("t5_rsp7", 32'(req_b.rsp_valid), 1);
    check_eq("t5_rdata7", 32'(req_b.rsp_rdata), 32'h77);
    tick();
    tick();
    check_eq("t5_hold", 32'(req_b.rsp_rdata), 32'h77);
    check_eq("t5_pulses", 32'(b_rsp_cnt - base), 2);

    // Out-of-range address 9.
    req_a.valid = 1'b1; req_a.we = 1'b0; req_a.addr = 8'd9;
    tick();
    req_a.valid = 1'b0;
`ifdef ADDR_CHECK_EN
    check_eq("t6_cs_off", 32'(sram_cs), 0);
    tick();
    tick();
    check_eq("t6_rsp", 32'(req_a.rsp_valid), 1);
    check_eq("t6_err", 32'(req_a.rsp_err), 1);
    check_eq("t6_rdata", 32'(req_a.rsp_rdata), 0);
    req_a.valid = 1'b1; req_a.we = 1'b1; req_a.addr = 8'd9; req_a.wdata = 8'h5A;
    tick();
    req_a.valid = 1'b0;
    check_eq("t6_wr_cs_off", 32'(sram_cs), 0);
    tick();
    check_eq("t6_wr_err", 32'(req_a.rsp_err), 1);
    check_eq("t6_wr_no_rsp", 32'(req_a.rsp_valid), 0);
    check_eq("t6_mem9", 32'(mem[9]), 32'h99);
`else
    check_eq("t6_cs_on", 32'(sram_cs), 1);
    check_eq("t6_addr", 32'(sram_addr), 9);
    tick();
    tick();
    check_eq("t6_rsp", 32'(req_a.rsp_valid), 1);
    check_eq("t6_err", 32'(req_a.rsp_err), 0);
    check_eq("t6_rdata", 32'(req_a.rsp_rdata), 32'h99);
`endif
    tick();

    check_eq("we_rd_exclusive", 32'(both_cnt), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
